spi_reg_ctrl: RTL and testbench

//  Transaction sequencer behind the SPI slave clock-domain synchronizer: consumes its clk-domain ticks
//  (spiStart/spiEnd/spiTxLoad/spiRxRdy) and turns each SPI frame into register-bus accesses.

---
 rtl/spi_reg_ctrl_pkg.sv | 25 ++
 rtl/spi_reg_ctrl_if.sv | 33 +++
 rtl/spi_reg_ctrl.sv | 135 +++++++++++++
 tb/tb_spi_reg_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// rtl/spi_reg_ctrl_pkg.sv - shared types and constants for the SPI register-bus sequencer
package spi_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 7;
    localparam logic [DEF_DATA_W-1:0] DEF_IDLE_TX = 8'hA5;

    localparam int   CMD_RW_BIT = DEF_DATA_W - 1;
    localparam logic RW_READ    = 1'b0;
    localparam logic RW_WRITE   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_FETCH,
        ST_RD_STAGE,
        ST_RD_DATA
    } ctrl_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - synchronizer ticks in, register bus and frame status out
interface spi_reg_ctrl_if #(
    parameter int DATA_W = spi_ctrl_pkg::DEF_DATA_W,
    parameter int ADDR_W = spi_ctrl_pkg::DEF_ADDR_W
) ();

    logic              spiBusy;
    logic              spiStart;
    logic              spiEnd;
    logic              spiTxLoad;
    logic              spiRxRdy;
    logic [DATA_W-1:0] rxData;
    logic [DATA_W-1:0] txData;
    logic [ADDR_W-1:0] regAddr;
    logic              regWrEn;
    logic [DATA_W-1:0] regWrData;
    logic              regRdEn;
    logic [DATA_W-1:0] regRdData;
    logic              xferDone;
    logic [7:0]        xferWords;
    logic              rdUnderrun;

    modport slave (
        input  spiBusy, spiStart, spiEnd, spiTxLoad, spiRxRdy, rxData, regRdData,
        output txData, regAddr, regWrEn, regWrData, regRdEn, xferDone, xferWords, rdUnderrun
    );

    modport master (
        output spiBusy, spiStart, spiEnd, spiTxLoad, spiRxRdy, rxData, regRdData,
        input  txData, regAddr, regWrEn, regWrData, regRdEn, xferDone, xferWords, rdUnderrun
    );

endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - turns SPI frames (command word + burst data) into register-bus accesses
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] IDLE_TX = DEF_IDLE_TX
) (
    input  logic          clk,
    input  logic          reset,
    spi_reg_ctrl_if.slave bus
);

    ctrl_state_t       state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        cnt, cnt_n;
    logic              busy_low_q;
    logic              end_evt;

    logic [DATA_W-1:0] tx_n, wd_n;
    logic [ADDR_W-1:0] ra_n;
    logic              wr_n, rd_n, done_n, und_n;
    logic [7:0]        words_n;

    // A frame that loses busy for two consecutive cycles is closed as if spiEnd had arrived.
    assign end_evt = bus.spiEnd || (busy_low_q && !bus.spiBusy);

    always_comb begin
        state_n = state;
        addr_n  = addr;
        cnt_n   = cnt;
        tx_n    = bus.txData;
        ra_n    = bus.regAddr;
        wr_n    = 1'b0;
        wd_n    = bus.regWrData;
        rd_n    = 1'b0;
        done_n  = 1'b0;
        words_n = bus.xferWords;
        und_n   = bus.rdUnderrun;

        if (state != ST_IDLE && end_evt) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            words_n = cnt;
            tx_n    = IDLE_TX;
        end else if (bus.spiStart) begin
            state_n = ST_CMD;
            tx_n    = IDLE_TX;
            cnt_n   = '0;
            und_n   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_CMD: begin
                    if (bus.spiRxRdy) begin
                        addr_n = bus.rxData[ADDR_W-1:0];
                        if (bus.rxData[DATA_W-1] == RW_WRITE) begin
                            state_n = ST_WR_DATA;
                        end else begin
                            state_n = ST_RD_FETCH;
                            rd_n    = 1'b1;
                            ra_n    = bus.rxData[ADDR_W-1:0];
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (bus.spiRxRdy) begin
                        wr_n   = 1'b1;
                        ra_n   = addr;
                        wd_n   = bus.rxData;
                        addr_n = addr + 1'b1;
                        cnt_n  = sat_inc(cnt);
                    end
                end
                ST_RD_FETCH: begin
                    state_n = ST_RD_STAGE;
                    if (bus.spiTxLoad) begin
                        und_n = 1'b1;
                        cnt_n = sat_inc(cnt);
                    end
                end
                ST_RD_STAGE: begin
                    state_n = ST_RD_DATA;
                    tx_n    = bus.regRdData;
                    addr_n  = addr + 1'b1;
                    if (bus.spiTxLoad) begin
                        und_n = 1'b1;
                        cnt_n = sat_inc(cnt);
                    end
                end
                ST_RD_DATA: begin
                    // Prefetch the next word as soon as the shifter takes the current one.
                    if (bus.spiTxLoad) begin
                        state_n = ST_RD_FETCH;
                        cnt_n   = sat_inc(cnt);
                        rd_n    = 1'b1;
                        ra_n    = addr;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            addr           <= '0;
            cnt            <= '0;
            busy_low_q     <= 1'b0;
            bus.txData     <= IDLE_TX;
            bus.regAddr    <= '0;
            bus.regWrEn    <= 1'b0;
            bus.regWrData  <= '0;
            bus.regRdEn    <= 1'b0;
            bus.xferDone   <= 1'b0;
            bus.xferWords  <= '0;
            bus.rdUnderrun <= 1'b0;
        end else begin
            state          <= state_n;
            addr           <= addr_n;
            cnt            <= cnt_n;
            busy_low_q     <= (state != ST_IDLE) && !bus.spiBusy;
            bus.txData     <= tx_n;
            bus.regAddr    <= ra_n;
            bus.regWrEn    <= wr_n;
            bus.regWrData  <= wd_n;
            bus.regRdEn    <= rd_n;
            bus.xferDone   <= done_n;
            bus.xferWords  <= words_n;
            bus.rdUnderrun <= und_n;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed scoreboard bench for spi_reg_ctrl with a 128x8 register file
module tb_spi_reg_ctrl;
    import spi_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    spi_reg_ctrl_if #(.DATA_W(8), .ADDR_W(7)) bus ();

    spi_reg_ctrl #(.DATA_W(8), .ADDR_W(7), .IDLE_TX(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] regs [128];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (bus.regWrEn === 1'b1) regs[bus.regAddr] <= bus.regWrData;
        if (bus.regRdEn === 1'b1) rd_q <= regs[bus.regAddr];
    end
    assign bus.regRdData = rd_q;

    logic [15:0] wr_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  done_q [$];
    logic [15:0] wexp;
    logic [7:0]  dexp;
    logic [7:0]  texp;
    logic [6:0]  model_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if ((bus.regWrEn | bus.regRdEn) === 1'b1)
            check("strobe_excl", 32'(bus.regWrEn & bus.regRdEn), 32'd0);
        if (bus.regWrEn === 1'b1) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                wexp = wr_q.pop_front();
                check("wr_addr", 32'(bus.regAddr), 32'(wexp[14:8]));
                check("wr_data", 32'(bus.regWrData), 32'(wexp[7:0]));
            end
        end
        if (bus.xferDone === 1'b1) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                dexp = done_q.pop_front();
                check("xfer_words", 32'(bus.xferWords), 32'(dexp));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        bus.spiBusy  = 1'b1;
        bus.spiStart = 1'b1;
        @(negedge clk);
        bus.spiStart = 1'b0;
    endtask

    task automatic rx_word(input logic [7:0] d);
        bus.rxData   = d;
        bus.spiRxRdy = 1'b1;
        @(negedge clk);
        bus.spiRxRdy = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        model_addr = cmd[6:0];
        rx_word(cmd);
    endtask

    task automatic wr_data(input logic [7:0] d);
        wr_q.push_back({1'b0, model_addr, d});
        model_addr = model_addr + 7'd1;
        rx_word(d);
    endtask

    task automatic tx_load(input bit chk);
        bus.spiTxLoad = 1'b1;
        if (chk) begin
            check("tx_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) begin
                texp = tx_q.pop_front();
                check("tx_data", 32'(bus.txData), 32'(texp));
            end
        end
        @(negedge clk);
        bus.spiTxLoad = 1'b0;
    endtask

    task automatic end_frame(input logic [7:0] words, input bit with_rx, input logic [7:0] d);
        done_q.push_back(words);
        bus.spiEnd  = 1'b1;
        bus.spiBusy = 1'b0;
        if (with_rx) begin
            bus.rxData   = d;
            bus.spiRxRdy = 1'b1;
        end
        @(negedge clk);
        bus.spiEnd   = 1'b0;
        bus.spiRxRdy = 1'b0;
        check("xfer_done", 32'(bus.xferDone), 32'd1);
        check("tx_idle_after_end", 32'(bus.txData), 32'hA5);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_txData"},     32'(bus.txData), 32'hA5);
        check({phase, "_regAddr"},    32'(bus.regAddr), 32'd0);
        check({phase, "_regWrEn"},    32'(bus.regWrEn), 32'd0);
        check({phase, "_regRdEn"},    32'(bus.regRdEn), 32'd0);
        check({phase, "_regWrData"},  32'(bus.regWrData), 32'd0);
        check({phase, "_xferDone"},   32'(bus.xferDone), 32'd0);
        check({phase, "_xferWords"},  32'(bus.xferWords), 32'd0);
        check({phase, "_rdUnderrun"}, 32'(bus.rdUnderrun), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.spiBusy   = 1'b0;
        bus.spiStart  = 1'b0;
        bus.spiEnd    = 1'b0;
        bus.spiTxLoad = 1'b0;
        bus.spiRxRdy  = 1'b0;
        bus.rxData    = '0;
        model_addr    = '0;
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // Write burst at 0x05
        start_frame();
        send_cmd(8'h85);
        wr_data(8'h11);
        wr_data(8'h22);
        wr_data(8'h33);
        idle(2);
        end_frame(8'd3, 1'b0, 8'h00);
        idle(2);

        // Preload 0x10..0x12 then read them back
        start_frame();
        send_cmd({RW_WRITE, 7'h10});
        wr_data(8'hAA);
        wr_data(8'hBB);
        wr_data(8'hCC);
        idle(1);
        end_frame(8'd3, 1'b0, 8'h00);
        idle(2);
        start_frame();
        tx_load(1'b0);
        send_cmd({RW_READ, 7'h10});
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        tx_q.push_back(8'hCC);
        idle(2);
        tx_load(1'b1);
        idle(3);
        tx_load(1'b1);
        idle(3);
        tx_load(1'b1);
        idle(3);
        end_frame(8'd3, 1'b0, 8'h00);
        check("rd_underrun_clean", 32'(bus.rdUnderrun), 32'd0);
        idle(2);

        // Address wrap
        start_frame();
        send_cmd(8'hFF);
        wr_data(8'h01);
        wr_data(8'h02);
        idle(1);
        end_frame(8'd2, 1'b0, 8'h00);
        idle(2);

        // Underrun, sticky until next start; empty frame reports zero words
        start_frame();
        send_cmd({RW_READ, 7'h10});
        tx_load(1'b0);
        idle(3);
        check("rd_underrun_set", 32'(bus.rdUnderrun), 32'd1);
        end_frame(8'd1, 1'b0, 8'h00);
        check("rd_underrun_sticky", 32'(bus.rdUnderrun), 32'd1);
        idle(2);
        start_frame();
        check("rd_underrun_cleared", 32'(bus.rdUnderrun), 32'd0);
        idle(1);
        end_frame(8'd0, 1'b0, 8'h00);
        idle(2);

        // spiEnd coincident with a data word drops that word
        start_frame();
        send_cmd({RW_WRITE, 7'h20});
        wr_data(8'h44);
        end_frame(8'd1, 1'b1, 8'h55);
        idle(3);

        // Busy lost without spiEnd
        start_frame();
        send_cmd({RW_WRITE, 7'h30});
        done_q.push_back(8'd0);
        bus.spiBusy = 1'b0;
        idle(2);
        check("busy_abort_done", 32'(bus.xferDone), 32'd1);
        idle(2);

        // Reset while the read data is being staged
        start_frame();
        send_cmd({RW_READ, 7'h10});
        idle(1);
        reset       = 1'b1;
        bus.spiBusy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midreset");
        idle(2);
        start_frame();
        send_cmd({RW_READ, 7'h11});
        tx_q.push_back(8'hBB);
        idle(2);
        tx_load(1'b1);
        idle(3);
        end_frame(8'd1, 1'b0, 8'h00);
        idle(3);

        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
